// File: rtl/cpa.sv
// Registered unsigned adder, (a + b) mod 2^WIDTH, with a two-level carry-lookahead core.
// Bits are grouped in fours; a top-level lookahead unit forms every group carry-in.
module cpa #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int unsigned NumGroups = (WIDTH + 3) / 4;
  localparam int unsigned PadWidth  = NumGroups * 4;

  // Padding bits have g = p = 0, which truncates the last group.
  logic [PadWidth-1:0]  g_pad, p_pad, c_pad;
  logic [NumGroups-1:0] grp_g, grp_p, grp_c;
  logic [WIDTH-1:0]     sum_d, sum_q;

  always_comb begin
    g_pad = PadWidth'(a & b);
    p_pad = PadWidth'(a ^ b);

    // Group generate/propagate terms.
    for (int k = 0; k < int'(NumGroups); k++) begin
      grp_g[k] = 1'b0;
      grp_p[k] = 1'b1;
      for (int t = 0; t < 4; t++) begin
        grp_g[k] = g_pad[k*4+t] | (p_pad[k*4+t] & grp_g[k]);
        grp_p[k] = grp_p[k] & p_pad[k*4+t];
      end
    end
  end

  // Second-level lookahead: each group carry-in as a flat sum of products.
  always_comb begin
    logic term;
    term = 1'b0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      grp_c[k] = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        grp_c[k] = grp_c[k] | term;
      end
    end
  end

  // First-level lookahead inside each group, seeded by the group carry-in.
  always_comb begin
    logic term;
    term = 1'b0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      for (int t = 0; t < 4; t++) begin
        term = grp_c[k];
        for (int u = 0; u < t; u++) begin
          term = term & p_pad[k*4+u];
        end
        c_pad[k*4+t] = term;
        for (int s = 0; s < t; s++) begin
          term = g_pad[k*4+s];
          for (int u = s + 1; u < t; u++) begin
            term = term & p_pad[k*4+u];
          end
          c_pad[k*4+t] = c_pad[k*4+t] | term;
        end
      end
    end
  end

  always_comb begin
    sum_d = WIDTH'(p_pad ^ c_pad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_cpa.sv
// Directed and random checks of cpa at WIDTH 13 (default), 16 and 7.
module tb_cpa;

  logic        clk;
  logic        rst;
  logic [12:0] a13, b13, s13;
  logic [15:0] a16, b16, s16;
  logic [6:0]  a7, b7, s7;
  int          checks;
  int          errors;

  cpa dut13 (.clk(clk), .rst(rst), .a(a13), .b(b13), .sum(s13));
  cpa #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .sum(s16));
  cpa #(.WIDTH(7))  dut7  (.clk(clk), .rst(rst), .a(a7), .b(b7), .sum(s7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a13 = 13'h1234; b13 = 13'h0567;
    a16 = 16'hffff; b16 = 16'h0003;
    a7  = 7'h55;    b7  = 7'h11;
    step();
    step();
    checks++;
    if (s13 !== 13'h0000) begin
      errors++; $display("FAIL reset_w13 got %h want 0000", s13);
    end
    checks++;
    if (s16 !== 16'h0000) begin
      errors++; $display("FAIL reset_w16 got %h want 0000", s16);
    end
    checks++;
    if (s7 !== 7'h00) begin
      errors++; $display("FAIL reset_w7 got %h want 00", s7);
    end
    // Release between edges; the first edge must load the operands present then.
    rst = 1'b0;
    a13 = 13'd3; b13 = 13'd4;
    a16 = 16'd0; b16 = 16'd0;
    a7  = 7'd0;  b7  = 7'd0;
    step();
    checks++;
    if (s13 !== 13'd7) begin
      errors++; $display("FAIL first_edge got %0d want 7", s13);
    end
  endtask

  task automatic test_exhaustive_low();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a13 = 13'(i);
        b13 = 13'(j);
        step();
        checks++;
        if (s13 !== 13'(i + j)) begin
          errors++;
          $display("FAIL exhaustive a=%0d b=%0d got %0d want %0d", i, j, s13, i + j);
        end
      end
    end
  endtask

  task automatic test_carries();
    logic [12:0] ta [0:7];
    logic [12:0] tb [0:7];
    logic [12:0] te [0:7];
    ta = '{13'h1fff, 13'h0fff, 13'h000f, 13'h00ff, 13'h1000, 13'h1555, 13'h1fff, 13'h0777};
    tb = '{13'h0001, 13'h0001, 13'h0001, 13'h0001, 13'h1000, 13'h0aaa, 13'h1fff, 13'h0889};
    te = '{13'h0000, 13'h1000, 13'h0010, 13'h0100, 13'h0000, 13'h1fff, 13'h1ffe, 13'h1000};
    for (int i = 0; i < 8; i++) begin
      a13 = ta[i];
      b13 = tb[i];
      step();
      checks++;
      if (s13 !== te[i]) begin
        errors++;
        $display("FAIL carry_%0d a=%h b=%h got %h want %h", i, ta[i], tb[i], s13, te[i]);
      end
    end
  endtask

  task automatic test_hold();
    a13 = 13'h0abc;
    b13 = 13'h0123;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s13 !== 13'h0bdf) begin
        errors++; $display("FAIL hold_%0d got %h want 0bdf", i, s13);
      end
    end
  endtask

  task automatic test_midstream_reset();
    a13 = 13'h0100;
    b13 = 13'h0023;
    step();
    checks++;
    if (s13 !== 13'h0123) begin
      errors++; $display("FAIL pre_reset got %h want 0123", s13);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (s13 !== 13'h0000) begin
      errors++; $display("FAIL async_reset got %h want 0000", s13);
    end
    a13 = 13'd5;
    b13 = 13'd7;
    step();
    checks++;
    if (s13 !== 13'h0000) begin
      errors++; $display("FAIL reset_hold got %h want 0000", s13);
    end
    #2;
    rst = 1'b0;
    step();
    checks++;
    if (s13 !== 13'd12) begin
      errors++; $display("FAIL post_release got %0d want 12", s13);
    end
  endtask

  task automatic test_random();
    logic [12:0] e13;
    logic [15:0] e16;
    logic [6:0]  e7;
    for (int i = 0; i < 10000; i++) begin
      a13 = 13'($urandom); b13 = 13'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      a7  = 7'($urandom);  b7  = 7'($urandom);
      e13 = 13'({1'b0, a13} + {1'b0, b13});
      e16 = 16'({1'b0, a16} + {1'b0, b16});
      e7  = 7'({1'b0, a7} + {1'b0, b7});
      step();
      checks++;
      if (s13 !== e13) begin
        errors++; $display("FAIL rand_w13 a=%h b=%h got %h want %h", a13, b13, s13, e13);
      end
      checks++;
      if (s16 !== e16) begin
        errors++; $display("FAIL rand_w16 a=%h b=%h got %h want %h", a16, b16, s16, e16);
      end
      checks++;
      if (s7 !== e7) begin
        errors++; $display("FAIL rand_w7 a=%h b=%h got %h want %h", a7, b7, s7, e7);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_exhaustive_low();
    test_carries();
    test_hold();
    test_midstream_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
